mult_pipe_param: RTL
====================

// Module: mult_pipe_param
// PURPOSE
//   Parametrised, fully pipelined integer multiplier for the dynamic pipeline's
//   MUL/MULT/MULTU path. Accepts one operation per cycle through a valid/ready
//   handshake and supports per-operation signed or unsigned mode.
//   Each operation carries a tag so the issue logic can match each result to
//   its instruction. Results are always in order.
//   The full-width product feeds the HI/LO writeback logic.
// PARAMETERS
//   WIDTH   32  operand width; power of two, >= 4
//   TAG_W   6   width of the tag carried alongside each operation
//   LAT     derived localparam = $clog2(WIDTH)+2, not overridable
// PORTS
//   clk        in   1        clock; all state changes on posedge
//   reset      in   1        synchronous, active-high
//   ena        in   1        global enable; 0 freezes the whole pipe
//   in_valid   in   1        operation offered
//   in_ready   out  1        operation accepted this cycle when in_valid & in_ready
//   in_signed  in   1        1: two's-complement operands; 0: unsigned
//   in_a       in   WIDTH    multiplicand
//   in_b       in   WIDTH    multiplier
//   in_tag     in   TAG_W    opaque tag, returned with the result
//   out_valid  out  1        result available
//   out_ready  in   1        consumer takes result when out_valid & out_ready
//   out_z      out  2*WIDTH  product
//   out_tag    out  TAG_W    tag of the operation that produced out_z
//   busy       out  1        1 while any pipe stage holds a valid operation
// BEHAVIOUR
//   - Pipe structure: LAT register stages, each with its own valid bit.
//     S0 computes |a|, |b| and neg = in_signed & (a[W-1]^b[W-1]), then registers
//     WIDTH masked and shifted partial products (each 2*WIDTH wide).
//     S1..S$clog2(WIDTH) form a binary adder tree, halving the term count per stage.
//     The final stage registers the tree sum, or its two's-complement negation
//     when neg is set.
//   - neg and tag travel with the data in every stage.
//   - advance = ena & (~out_valid | out_ready). All stages shift together on advance.
//     When advance=0, every data and valid register holds its value.
//   - in_ready = advance, combinational. An operation accepted in cycle t appears with
//     out_valid=1 in cycle t+LAT if no stall occurs; each stall cycle adds one.
//     For WIDTH=32, LAT=7.
//   - Throughput is 1 op/cycle. A bubble (in_valid=0 on advance) enters S0 as valid=0.
//   - Data registers only load on advance. Valid bits are the only registers that are
//     cleared by reset.
//   - out_z and out_tag are held stable while out_valid & ~out_ready.
//     No result is dropped or duplicated, and order equals acceptance order.
//   - Width rules: all arithmetic is 2*WIDTH bits and sums wrap modulo 2^(2W).
//     Overflow is impossible because |a|*|b| < 2^(2W).
//   - Signed -2^(W-1) has magnitude 2^(W-1), which is representable unsigned in W bits.
//     -2^(W-1) * -2^(W-1) = 2^(2W-2).
//   - A zero product with neg=1 yields 0.
//   - Unsigned mode never negates, whatever the operand MSBs.
//   - Reset: out_valid=0, busy=0 and all stage valids are 0 from the next cycle.
//     in_ready follows ena.
//   - Reset mid-operation discards all in-flight operations with no later output.
//     Reset has priority over ena and the handshakes.
//   - ena=0 with out_valid=1: the output is held and out_ready is ignored; the
//     transfer completes once ena returns.
//   - busy = OR of all stage valid bits, including the output stage.
// TESTING
//   - Unsigned, WIDTH=32: a=b=0xFFFFFFFF, tag=5, out_ready=1.
//     -> out_z=0xFFFFFFFE00000001 and out_tag=5, exactly 7 cycles after accept.
//   - Signed: -3*5 -> 0xFFFFFFFFFFFFFFF1; -1*-1 -> 0x1;
//     0x80000000*0x80000000 -> 0x4000000000000000; 0*-7 -> 0.
//   - Unsigned 0x80000000*0x2 -> 0x0000000100000000, with no sign fix applied.
//   - 64 back-to-back random ops with tags 0..63 and out_ready toggled pseudo-randomly.
//     -> results in order, every product matches the model, none lost or repeated,
//     out_z stable during stalls.
//   - Fill the pipe with 7 ops, then assert reset for 1 cycle.
//     -> out_valid=0 and busy=0 next cycle; no stale result follows.
//   - ena=0 for 5 cycles mid-stream. -> in_ready=0 and outputs held.
//     Resume ena -> latency extended by exactly 5 cycles.

Source files
------------

// File: rtl/mult_pipe_param.sv
// mult_pipe_param
//   Fully pipelined integer multiplier for the MUL/MULT/MULTU path.
//   One operation per cycle, per-operation signed/unsigned mode, in-order
//   results, each carrying the tag it was issued with.
//
//   S0        : |a|, |b|, sign of result; WIDTH masked/shifted partial products
//   S1..SLOG  : binary adder tree, halving the term count per stage
//   SLOG+1    : registered sum, negated when the result is negative
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ena                 global enable, 0 freezes the whole pipe
//   in_valid/in_ready   operation handshake (in_ready is combinational)
//   in_signed           1: two's-complement operands, 0: unsigned
//   in_a, in_b, in_tag  operands and opaque tag
//   out_valid/out_ready result handshake
//   out_z, out_tag      2*WIDTH product and its tag
//   busy                any stage holds a valid operation

// One partial product: a_abs shifted to its bit position, masked by b_abs bit.
module mult_pp_lane #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 0
) (
   input  logic [WIDTH-1:0]   a_abs,
   input  logic               b_bit,
   output logic [2*WIDTH-1:0] pp
);
   assign pp = b_bit ? ({{WIDTH{1'b0}}, a_abs} << SHIFT) : '0;
endmodule

module mult_pipe_param #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ena,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_z,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);
   localparam int LOG = $clog2(WIDTH);
   localparam int LAT = LOG + 2;

   logic                          advance;
   logic [LAT-1:0]                vld_pipe;   // vld_pipe[k] = stage Sk valid
   logic [LAT-1:0][TAG_W-1:0]     tag_pipe;
   logic [LAT-2:0]                neg_pipe;   // sign travels to the last tree stage
   logic [WIDTH-1:0]              a_abs, b_abs;
   logic                          neg_s0;
   logic [WIDTH-1:0][2*WIDTH-1:0] pp;
   logic [2*WIDTH-1:0]            z_q;

   // Adder tree in heap layout: leaves node[WIDTH..2*WIDTH-1] are the S0
   // partial products, node[j] = node[2j] + node[2j+1], root is node[1].
   // A node at depth d is registered in stage LOG-d, so simply updating every
   // node on each advance gives a correctly pipelined tree.
   logic [2*WIDTH-1:1][2*WIDTH-1:0] node;

   assign out_valid = vld_pipe[LAT-1];
   assign advance   = ena & (~out_valid | out_ready);
   assign in_ready  = advance;
   assign busy      = |vld_pipe;
   assign out_z     = z_q;
   assign out_tag   = tag_pipe[LAT-1];

   // -2^(W-1) maps onto itself, which is the correct unsigned magnitude.
   assign a_abs  = (in_signed & in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
   assign b_abs  = (in_signed & in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;
   assign neg_s0 = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      mult_pp_lane #(.WIDTH(WIDTH), .SHIFT(i)) u_lane (
         .a_abs (a_abs),
         .b_bit (b_abs[i]),
         .pp    (pp[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset)
         vld_pipe <= '0;
      else if (advance)
         vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
   end

   // Data registers carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int i = 0; i < WIDTH; i++)
            node[WIDTH+i] <= pp[i];
         for (int j = 1; j < WIDTH; j++)
            node[j] <= node[2*j] + node[2*j+1];
         neg_pipe <= {neg_pipe[LAT-3:0], neg_s0};
         tag_pipe <= {tag_pipe[LAT-2:0], in_tag};
         // A zero sum negates to zero, so no special case is needed.
         z_q      <= neg_pipe[LAT-2] ? (~node[1] + 1'b1) : node[1];
      end
   end
endmodule
